// File: rtl/tone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tone_scheduler
//  Purpose  : Round-robin arbiter that lends the single square-wave tone
//             generator to one of four note requesters at a time. Each grant
//             plays a fixed-length note (tone_en high), then a fixed-length
//             silent gap, then returns to IDLE to arbitrate again.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      system clock, rising edge
//    rst_n        in   1      asynchronous active-low reset
//    req          in   4      level requests, one bit per requester
//    stop         in   1      synchronous abort back to IDLE, silent
//    tone_en      out  1      enable to the tone generator
//    half_period  out  DIV_W  half-period divisor for the tone generator
//    grant        out  4      one-hot requester being served, 0 when idle
//    done         out  1      one-cycle pulse in the first gap cycle
//    busy         out  1      high while a note or its gap is in progress
// ============================================================================
module tone_scheduler #(
    parameter int          DIV_W       = 17,
    parameter int unsigned DIV0        = 113636,
    parameter int unsigned DIV1        = 95556,
    parameter int unsigned DIV2        = 75843,
    parameter int unsigned DIV3        = 63776,
    parameter int unsigned NOTE_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic             stop,
    output logic             tone_en,
    output logic [DIV_W-1:0] half_period,
    output logic [3:0]       grant,
    output logic             done,
    output logic             busy
);

    // One counter serves both phases, so it is sized for the longer one.
    localparam int unsigned C_MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int          C_CNT_W      = $clog2(C_MAX_CYCLES) + 1;
    localparam logic [C_CNT_W-1:0] C_NOTE_LOAD = C_CNT_W'(NOTE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LOAD  = C_CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [1:0]         r_last;     // requester served most recently

    logic               w_any;
    logic [1:0]         w_sel;
    logic [DIV_W-1:0]   w_div;

    // Search starts just after the last winner and wraps round to it, so the
    // previous winner has the lowest priority on the next arbitration.
    always_comb begin
        w_any = 1'b0;
        w_sel = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_any && req[r_last + 2'(i)]) begin
                w_any = 1'b1;
                w_sel = r_last + 2'(i);
            end
        end
    end

    always_comb begin
        w_div = '0;
        case (w_sel)
            2'd0:    w_div = DIV_W'(DIV0);
            2'd1:    w_div = DIV_W'(DIV1);
            2'd2:    w_div = DIV_W'(DIV2);
            default: w_div = DIV_W'(DIV3);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= 2'd3;
            tone_en     <= 1'b0;
            half_period <= '0;
            grant       <= 4'b0000;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else if (stop) begin
            // Abort wins over expiry and over a fresh grant; r_last is kept
            // so the aborted requester still counts as just served.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            tone_en     <= 1'b0;
            half_period <= '0;
            grant       <= 4'b0000;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        grant       <= 4'b0001 << w_sel;
                        half_period <= w_div;
                        tone_en     <= 1'b1;
                        busy        <= 1'b1;
                        r_last      <= w_sel;
                        r_cnt       <= C_NOTE_LOAD;
                        r_state     <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (r_cnt == '0) begin
                        // done lands in the first gap cycle while grant is
                        // still valid, identifying whose note finished.
                        tone_en <= 1'b0;
                        done    <= 1'b1;
                        r_cnt   <= C_GAP_LOAD;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        grant       <= 4'b0000;
                        half_period <= '0;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_scheduler
//  Purpose  : Self-checking bench for tone_scheduler with NOTE_CYCLES=8 and
//             GAP_CYCLES=3. A note-level reference model (age of the current
//             note since its grant edge) predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tone_scheduler;

    localparam int NOTE = 8;
    localparam int GAP  = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic        stop;
    logic        tone_en;
    logic [16:0] half_period;
    logic [3:0]  grant;
    logic        done;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit m_active;
    int m_age;
    int m_k;
    int m_last;
    int divs [4] = '{113636, 95556, 75843, 63776};

    logic       prev_tone;
    logic [3:0] seen [$];

    tone_scheduler #(
        .DIV_W       (17),
        .NOTE_CYCLES (NOTE),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .stop        (stop),
        .tone_en     (tone_en),
        .half_period (half_period),
        .grant       (grant),
        .done        (done),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_last   = 3;
    endtask

    // Advance the model by one rising edge using the inputs the DUT sampled.
    task automatic model_edge();
        bit found;
        if (!rst_n) begin
            model_reset();
        end else if (stop) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            found = 1'b0;
            for (int j = 1; j <= 4; j++) begin
                int c;
                c = (m_last + j) % 4;
                if (!found && req[c]) begin
                    found    = 1'b1;
                    m_k      = c;
                    m_last   = c;
                    m_active = 1'b1;
                    m_age    = 0;
                end
            end
        end else begin
            m_age++;
            if (m_age == NOTE + GAP) m_active = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".tone_en"},     32'(tone_en),     32'(m_active && m_age < NOTE));
        chk({tag, ".done"},        32'(done),        32'(m_active && m_age == NOTE));
        chk({tag, ".busy"},        32'(busy),        32'(m_active));
        chk({tag, ".grant"},       32'(grant),       m_active ? (32'd1 << m_k) : 32'd0);
        chk({tag, ".half_period"}, 32'(half_period), m_active ? 32'(divs[m_k]) : 32'd0);
    endtask

    // Drive inputs on the falling edge, let the rising edge act, check on the
    // following falling edge.
    task automatic cycle(input logic [3:0] r, input logic s, input string tag);
        req  = r;
        stop = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
        if (tone_en === 1'b1 && prev_tone === 1'b0) seen.push_back(grant);
        prev_tone = tone_en;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) cycle(4'b0000, 1'b0, "reset");
        rst_n = 1'b1;
        seen.delete();
        prev_tone = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        stop      = 1'b0;
        prev_tone = 1'b0;
        model_reset();

        // Reset then single request
        do_reset(5);
        chk("rst.grant", 32'(grant), 32'd0);
        chk("rst.busy",  32'(busy),  32'd0);
        cycle(4'b0001, 1'b0, "single");
        chk("single.grant0",  32'(grant),       32'd1);
        chk("single.hp0",     32'(half_period), 32'd113636);
        chk("single.tone_on", 32'(tone_en),     32'd1);
        repeat (14) cycle(4'b0000, 1'b0, "single");

        // Round-robin order with all requests held
        do_reset(2);
        repeat (50) cycle(4'b1111, 1'b0, "rr");
        chk("rr.count", 32'(seen.size() >= 5), 32'd1);
        chk("rr.g0", 32'(seen[0]), 32'b0001);
        chk("rr.g1", 32'(seen[1]), 32'b0010);
        chk("rr.g2", 32'(seen[2]), 32'b0100);
        chk("rr.g3", 32'(seen[3]), 32'b1000);
        chk("rr.g4", 32'(seen[4]), 32'b0001);

        // Late arrival fairness
        do_reset(2);
        repeat (3)  cycle(4'b0001, 1'b0, "late");
        repeat (34) cycle(4'b0101, 1'b0, "late");
        chk("late.g0", 32'(seen[0]), 32'b0001);
        chk("late.g1", 32'(seen[1]), 32'b0100);
        chk("late.g2", 32'(seen[2]), 32'b0001);

        // Request dropped on the 2nd PLAY cycle
        do_reset(2);
        cycle(4'b0010, 1'b0, "drop");
        cycle(4'b0010, 1'b0, "drop");
        repeat (12) cycle(4'b0000, 1'b0, "drop");
        chk("drop.grant_idle", 32'(grant), 32'd0);

        // Stop on PLAY cycle 4
        do_reset(2);
        cycle(4'b0001, 1'b0, "stop");
        repeat (3) cycle(4'b0000, 1'b0, "stop");
        cycle(4'b0001, 1'b1, "stop");
        chk("stop.tone",  32'(tone_en), 32'd0);
        chk("stop.grant", 32'(grant),   32'd0);
        chk("stop.busy",  32'(busy),    32'd0);
        chk("stop.done",  32'(done),    32'd0);
        cycle(4'b1111, 1'b0, "stop_next");
        chk("stop.next_grant", 32'(grant), 32'b0010);
        repeat (12) cycle(4'b0000, 1'b0, "stop_tail");

        // Asynchronous reset between edges during PLAY
        cycle(4'b0100, 1'b0, "areset");
        repeat (2) cycle(4'b0000, 1'b0, "areset");
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset.tone",  32'(tone_en),     32'd0);
        chk("areset.grant", 32'(grant),       32'd0);
        chk("areset.busy",  32'(busy),        32'd0);
        chk("areset.hp",    32'(half_period), 32'd0);
        repeat (2) cycle(4'b0000, 1'b0, "areset_hold");
        rst_n = 1'b1;
        cycle(4'b1111, 1'b0, "areset_next");
        chk("areset.next_grant", 32'(grant), 32'b0001);

        // Randomized traffic with occasional aborts
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r;
            logic       s;
            r = 4'($urandom);
            s = ($urandom_range(0, 19) == 0);
            cycle(r, s, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
